// File: rtl/lcd_timing_controller.sv
// lcd_timing_controller
//
// Dot-clock scheduler for the LCD pipeline. Walks every scanline through
// OAM scan (mode 2), draw (mode 3), H-blank (mode 0) and, below the visible
// area, V-blank (mode 1). Emits the per-line drawline start pulse, the
// frame_start and vblank_irq pulses, CPU lockouts for OAM/VRAM, the LY
// counter, the LY==LYC flag and the STAT interrupt request.
//
// Ports:
//   clk, reset_n     system clock, asynchronous active-low reset
//   dot_en           one-cycle dot strobe; all timing advances only on it
//   lcd_enable       LCDC bit 7; low forces the block idle
//   lyc              LYC compare value
//   stat_sel         STAT source enables {LYC, mode2, mode1, mode0}
//   ly, mode         current line and mode
//   lyc_match        registered ly == lyc
//   drawline         one-clk pulse at the start of mode 3
//   frame_start      one-clk pulse when line 0 dot 0 begins
//   vblank_irq       one-clk pulse on entry to V-blank
//   stat_irq         one-clk STAT interrupt request
//   oam_locked       CPU OAM access blocked (modes 2 and 3)
//   vram_locked      CPU VRAM access blocked (mode 3)
//
// Build option:
//   LCD_STAT_BLOCKING_EN  defined: stat_irq fires on the rising edge of the
//                         ORed STAT line. Undefined: each enabled source is
//                         edge-detected on its own.

module lcd_timing_controller #(
    parameter int unsigned DOTS_PER_LINE = 456,
    parameter int unsigned OAM_DOTS      = 80,
    parameter int unsigned DRAW_DOTS     = 172,
    parameter int unsigned VISIBLE_LINES = 144,
    parameter int unsigned TOTAL_LINES   = 154
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dot_en,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_sel,
    output logic [7:0] ly,
    output logic [1:0] mode,
    output logic       lyc_match,
    output logic       drawline,
    output logic       frame_start,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       oam_locked,
    output logic       vram_locked
);

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_DRAW   = 2'd3
    } mode_e;

    localparam logic [8:0] DOT_LAST    = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] DOT_DRAW    = 9'(OAM_DOTS);
    localparam logic [8:0] DOT_HBLANK  = 9'(OAM_DOTS + DRAW_DOTS);
    localparam logic [7:0] LINE_LAST   = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] LINE_VBLANK = 8'(VISIBLE_LINES);

`ifdef LCD_STAT_BLOCKING_EN
    localparam int unsigned STAT_W = 1;
`else
    localparam int unsigned STAT_W = 4;
`endif

    logic [8:0]        dot_q, dot_d;
    logic [7:0]        ly_q, ly_d;
    mode_e             mode_q, mode_d;
    logic              run_q;
    logic              drawline_q, drawline_d;
    logic              frame_start_q, frame_start_d;
    logic              vblank_q, vblank_d;
    logic              oam_lock_q, oam_lock_d;
    logic              vram_lock_q, vram_lock_d;
    logic              lyc_match_q;
    logic [3:0]        stat_cond;
    logic [STAT_W-1:0] stat_line_q, stat_line_d;
    logic              stat_irq_q, stat_irq_d;
    logic              advance;
    logic              start;

    function automatic mode_e mode_of(input logic [8:0] d, input logic [7:0] l);
        mode_e m;
        if (l >= LINE_VBLANK)    m = MODE_VBLANK;
        else if (d < DOT_DRAW)   m = MODE_OAM;
        else if (d < DOT_HBLANK) m = MODE_DRAW;
        else                     m = MODE_HBLANK;
        return m;
    endfunction

    // run_q remembers that the LCD was enabled last clk; its absence marks
    // the enable-start edge, which loads line 0 dot 0 without counting.
    assign start   = lcd_enable & ~run_q;
    assign advance = lcd_enable & run_q & dot_en;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dot_q         <= '0;
            ly_q          <= '0;
            mode_q        <= MODE_HBLANK;
            run_q         <= 1'b0;
            drawline_q    <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
            oam_lock_q    <= 1'b0;
            vram_lock_q   <= 1'b0;
            lyc_match_q   <= 1'b0;
            stat_line_q   <= '0;
            stat_irq_q    <= 1'b0;
        end else begin
            dot_q         <= dot_d;
            ly_q          <= ly_d;
            mode_q        <= mode_d;
            run_q         <= lcd_enable;
            drawline_q    <= drawline_d;
            frame_start_q <= frame_start_d;
            vblank_q      <= vblank_d;
            oam_lock_q    <= oam_lock_d;
            vram_lock_q   <= vram_lock_d;
            lyc_match_q   <= (ly_q == lyc);
            stat_line_q   <= stat_line_d;
            stat_irq_q    <= stat_irq_d;
        end
    end

    // Next state: disable beats everything, including a dot wrap
    always_comb begin
        dot_d  = dot_q;
        ly_d   = ly_q;
        mode_d = mode_q;
        if (!lcd_enable) begin
            dot_d  = '0;
            ly_d   = '0;
            mode_d = MODE_HBLANK;
        end else if (start) begin
            dot_d  = '0;
            ly_d   = '0;
            mode_d = MODE_OAM;
        end else if (dot_en) begin
            if (dot_q == DOT_LAST) begin
                dot_d = '0;
                ly_d  = (ly_q == LINE_LAST) ? '0 : ly_q + 8'd1;
            end else begin
                dot_d = dot_q + 9'd1;
            end
            mode_d = mode_of(dot_d, ly_d);
        end
    end

    // Outputs: registered alongside mode so they always agree with it
    always_comb begin
        drawline_d    = advance & (mode_d == MODE_DRAW) & (mode_q != MODE_DRAW);
        vblank_d      = advance & (mode_d == MODE_VBLANK) & (mode_q != MODE_VBLANK);
        frame_start_d = start | (advance & (dot_d == '0) & (ly_d == '0));
        oam_lock_d    = (mode_d == MODE_OAM) | (mode_d == MODE_DRAW);
        vram_lock_d   = (mode_d == MODE_DRAW);

        stat_cond = {stat_sel[3] & lyc_match_q,
                     stat_sel[2] & (mode_q == MODE_OAM),
                     stat_sel[1] & (mode_q == MODE_VBLANK),
                     stat_sel[0] & (mode_q == MODE_HBLANK)};
`ifdef LCD_STAT_BLOCKING_EN
        stat_line_d = |stat_cond;
`else
        stat_line_d = stat_cond;
`endif
        // Source history keeps tracking while disabled; only the request is gated.
        stat_irq_d = lcd_enable & (|(stat_line_d & ~stat_line_q));
    end

    assign ly          = ly_q;
    assign mode        = mode_q;
    assign lyc_match   = lyc_match_q;
    assign drawline    = drawline_q;
    assign frame_start = frame_start_q;
    assign vblank_irq  = vblank_q;
    assign stat_irq    = stat_irq_q;
    assign oam_locked  = oam_lock_q;
    assign vram_locked = vram_lock_q;

endmodule

// File: tb/tb_lcd_timing_controller.sv
`timescale 1ns/1ps
module tb_lcd_timing_controller;

    // Default line geometry; the frame is shortened to keep the run compact.
    localparam int unsigned DPL   = 456;
    localparam int unsigned OAMD  = 80;
    localparam int unsigned DRAWD = 172;
    localparam int unsigned VIS   = 20;
    localparam int unsigned TOT   = 26;
    localparam int unsigned FRAME = DPL * TOT;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       dot_en;
    logic       lcd_enable;
    logic [7:0] lyc;
    logic [3:0] stat_sel;
    logic [7:0] ly;
    logic [1:0] mode;
    logic       lyc_match, drawline, frame_start, vblank_irq, stat_irq;
    logic       oam_locked, vram_locked;

    lcd_timing_controller #(
        .DOTS_PER_LINE (DPL),
        .OAM_DOTS      (OAMD),
        .DRAW_DOTS     (DRAWD),
        .VISIBLE_LINES (VIS),
        .TOTAL_LINES   (TOT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .dot_en      (dot_en),
        .lcd_enable  (lcd_enable),
        .lyc         (lyc),
        .stat_sel    (stat_sel),
        .ly          (ly),
        .mode        (mode),
        .lyc_match   (lyc_match),
        .drawline    (drawline),
        .frame_start (frame_start),
        .vblank_irq  (vblank_irq),
        .stat_irq    (stat_irq),
        .oam_locked  (oam_locked),
        .vram_locked (vram_locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ly;
        logic [1:0] mode;
        logic       lycm;
        logic       dl;
        logic       fs;
        logic       vb;
        logic       irq;
        logic       oam;
        logic       vram;
    } snap_t;

    snap_t exp_q[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned cnt_fs = 0, cnt_dl = 0, cnt_vb = 0;
    int unsigned last_fs_cyc = 0, fs_period = 0;
    int unsigned last_dl_cyc = 0, dl_period = 0;

    // Reference model: a single position within the frame plus a run flag
    bit          m_run;
    int unsigned m_pos;
    logic [3:0]  m_hist;
    snap_t       e;
    logic [7:0]  cur_lyc;
    logic [3:0]  cur_sel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_pos  = 0;
        m_hist = '0;
        e      = '0;
    endtask

    task automatic model_derive();
        int unsigned l, d;
        if (m_run) begin
            l = m_pos / DPL;
            d = m_pos % DPL;
            e.ly = 8'(l);
            if (l >= VIS)             e.mode = 2'd1;
            else if (d < OAMD)        e.mode = 2'd2;
            else if (d < OAMD + DRAWD) e.mode = 2'd3;
            else                      e.mode = 2'd0;
        end else begin
            e.ly   = '0;
            e.mode = 2'd0;
        end
        e.oam  = (e.mode == 2'd2) || (e.mode == 2'd3);
        e.vram = (e.mode == 2'd3);
    endtask

    // Expected state after a clock edge, from the inputs held across it
    task automatic model_edge();
        logic [3:0] cond;
        logic       rise;
        if (!reset_n) begin
            model_reset();
            return;
        end
        cond = {stat_sel[3] & e.lycm, stat_sel[2] & (e.mode == 2'd2),
                stat_sel[1] & (e.mode == 2'd1), stat_sel[0] & (e.mode == 2'd0)};
`ifdef LCD_STAT_BLOCKING_EN
        rise   = (|cond) & ~m_hist[0];
        m_hist = {3'b000, |cond};
`else
        rise   = |(cond & ~m_hist);
        m_hist = cond;
`endif
        e.irq  = lcd_enable & rise;
        e.lycm = (e.ly == lyc);
        e.fs = 1'b0;
        e.dl = 1'b0;
        e.vb = 1'b0;
        if (!lcd_enable) begin
            m_run = 1'b0;
            m_pos = 0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_pos = 0;
            e.fs  = 1'b1;
        end else if (dot_en) begin
            m_pos = (m_pos + 1) % FRAME;
            e.fs  = (m_pos == 0);
            e.dl  = ((m_pos % DPL) == OAMD) && ((m_pos / DPL) < VIS);
            e.vb  = (m_pos == VIS * DPL);
        end
        model_derive();
    endtask

    // One clock: model the edge, then apply the next inputs and queue the
    // response the monitor should see before the following edge.
    task automatic step(input logic rn, input logic en, input logic de);
        @(posedge clk);
        model_edge();
        #1;
        reset_n    = rn;
        lcd_enable = en;
        dot_en     = de;
        lyc        = cur_lyc;
        stat_sel   = cur_sel;
        if (!reset_n) model_reset();
        exp_q.push_back(e);
    endtask

    // Monitor
    initial begin
        snap_t s;
        forever begin
            @(negedge clk);
            cyc++;
            if (frame_start) begin
                cnt_fs++;
                if (last_fs_cyc != 0) fs_period = cyc - last_fs_cyc;
                last_fs_cyc = cyc;
            end
            if (drawline) begin
                cnt_dl++;
                if (last_dl_cyc != 0) dl_period = cyc - last_dl_cyc;
                last_dl_cyc = cyc;
            end
            if (vblank_irq) cnt_vb++;
            if (exp_q.size() != 0) begin
                s = exp_q.pop_front();
                check("ly",          32'(ly),          32'(s.ly));
                check("mode",        32'(mode),        32'(s.mode));
                check("lyc_match",   32'(lyc_match),   32'(s.lycm));
                check("drawline",    32'(drawline),    32'(s.dl));
                check("frame_start", 32'(frame_start), 32'(s.fs));
                check("vblank_irq",  32'(vblank_irq),  32'(s.vb));
                check("stat_irq",    32'(stat_irq),    32'(s.irq));
                check("oam_locked",  32'(oam_locked),  32'(s.oam));
                check("vram_locked", 32'(vram_locked), 32'(s.vram));
            end
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        int unsigned b_fs, b_dl, b_vb;
        reset_n    = 1'b0;
        lcd_enable = 1'b1;
        dot_en     = 1'b1;
        cur_lyc    = 8'd10;
        cur_sel    = 4'b1000;
        lyc        = cur_lyc;
        stat_sel   = cur_sel;
        model_reset();

        // Reset held, then released with the LCD enabled
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);

        // Full frame plus one line; LYC source on line 10, then H-blank+LYC
        // sources with lyc=0 from the last line into the next frame.
        b_fs = cnt_fs; b_dl = cnt_dl; b_vb = cnt_vb;
        for (int i = 0; i < int'(1 + FRAME + DPL); i++) begin
            if (m_run && (m_pos / DPL) == TOT - 1) begin
                cur_lyc = 8'd0;
                cur_sel = 4'b1001;
            end
            step(1'b1, 1'b1, 1'b1);
        end
        @(negedge clk); #1;
        check("frame_start_count", cnt_fs - b_fs, 2);
        check("drawline_count",    cnt_dl - b_dl, VIS + 1);
        check("vblank_count",      cnt_vb - b_vb, 1);
        check("frame_length",      fs_period,     FRAME);

        // Random dot strobes, STAT sources, LYC and occasional disables
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 199) == 0) cur_sel = 4'($urandom);
            if ($urandom_range(0, 299) == 0) cur_lyc = 8'($urandom_range(0, TOT));
            step(1'b1, ($urandom_range(0, 999) != 0), ($urandom_range(0, 3) != 0));
        end

        // Disable while at line 12 dot 200, then re-enable
        cur_sel = 4'b1111;
        cur_lyc = 8'd12;
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < int'(FRAME) && !(m_run && m_pos == 12 * DPL + 199); k++)
            step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);

        // Disable landing on a dot wrap
        for (int k = 0; k < int'(DPL) && !(m_run && (m_pos % DPL) == DPL - 2); k++)
            step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);

        // dot_en every 4th clk from a fresh enable
        cur_sel = 4'b0111;
        for (int i = 0; i < int'(8 * DPL + 20); i++)
            step(1'b1, 1'b1, (i % 4) == 0);
        @(negedge clk); #1;
        check("line_length_clk", dl_period, 4 * DPL);

        // Asynchronous reset mid-frame, then release with the LCD enabled
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 600; i++) step(1'b1, 1'b1, 1'b1);

        @(negedge clk); #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_timing_controller.md
# lcd_timing_controller

Dot-clock scheduler for the LCD pipeline. Sequences every scanline through OAM-scan, draw, H-blank and V-blank modes, and drives the per-line `drawline` start pulse consumed by the background/sprite renderer. Arbitrates CPU access to VRAM and OAM against the renderer via lock outputs. Produces the LY counter, the LY=LYC flag and the V-blank/STAT interrupt requests for the interrupt controller.

## Interface
- `DOTS_PER_LINE`, default 456: dots per scanline.
- `OAM_DOTS`, default 80: mode-2 length in dots.
- `DRAW_DOTS`, default 172: mode-3 length in dots, fixed.
- `VISIBLE_LINES`, default 144: lines 0..VISIBLE_LINES-1 are drawn.
- `TOTAL_LINES`, default 154: lines per frame, including V-blank.
- `clk`, in, 1: system clock, the same clock as `db.clk`.
- `reset_n`, in, 1: asynchronous active-low reset.
- `dot_en`, in, 1: one-cycle dot strobe; all timing advances only on cycles where it is 1.
- `lcd_enable`, in, 1: LCDC bit 7.
- `lyc`, in, 8: LYC register value.
- `stat_sel`, in, 4: STAT bits 6:3, ordered {LYC, mode2, mode1, mode0}.
- `ly`, out, 8: current line.
- `mode`, out, 2: 0 = H-blank, 1 = V-blank, 2 = OAM scan, 3 = draw.
- `lyc_match`, out, 1: registered `ly == lyc`.
- `drawline`, out, 1: one-clk pulse at the start of mode 3.
- `frame_start`, out, 1: one-clk pulse when line 0 dot 0 begins.
- `vblank_irq`, out, 1: one-clk pulse on entry to line VISIBLE_LINES.
- `stat_irq`, out, 1: one-clk STAT interrupt request.
- `oam_locked`, out, 1: CPU OAM access is blocked.
- `vram_locked`, out, 1: CPU VRAM access is blocked.

## Operation
**Counters**
- `dot` is 9 bits and `ly` is 8 bits.
- On `dot_en`, `dot` increments.
- At `dot == DOTS_PER_LINE-1`, `dot` wraps to 0 and `ly` increments.
- At `ly == TOTAL_LINES-1` with a dot wrap, `ly` wraps to 0.

**Mode state machine**
- `mode` is a function of the next (`dot`, `ly`) and is registered on the same edge as the counters, so it always matches them.
- For `ly < VISIBLE_LINES`:
  - `dot < OAM_DOTS` gives mode 2.
  - `dot < OAM_DOTS+DRAW_DOTS` gives mode 3.
  - Otherwise mode 0.
- For `ly >= VISIBLE_LINES`, mode is 1.
- Transition order is 2→3→0→2 per visible line, then 0→1 at line VISIBLE_LINES, then 1→2 at the frame wrap.

**Pulses**
- `drawline` = 1 on the edge where `mode` becomes 3.
- `frame_start` = 1 on the edge where the counters become (0,0), including the enable start.
- `vblank_irq` = 1 on the edge where `mode` becomes 1.

**Arbitration**
- `oam_locked` = mode is 2 or 3.
- `vram_locked` = mode is 3.
- Both are registered together with `mode`.

**STAT**
- `stat_line` = (sel[0]&mode==0) | (sel[1]&mode==1) | (sel[2]&mode==2) | (sel[3]&lyc_match).
- `stat_irq` <= `stat_line` & ~`stat_line_q`.

**LCD disable**
- While `lcd_enable` = 0: `dot`=0, `ly`=0, `mode`=0, both locks are 0, and all pulses are 0. `lyc_match` still tracks (0==`lyc`).
- Disabling mid-line takes effect on the next clk, regardless of `dot_en`.

**Enable**
- On the first clk with `lcd_enable` = 1 after being 0, state loads line 0, dot 0, mode 2.
- `frame_start` pulses on that edge.
- The dot count begins on the next `dot_en`.

**Reset**
- All outputs are 0.
- `dot`, `ly` and `stat_line_q` are 0.
- An assertion mid-frame clears immediately (asynchronous).
- After release, behaviour is as for the enable start if `lcd_enable` = 1.

## Timing
- The counter, `mode`, `ly` and lock updates are registered on the `dot_en` edge. This is zero additional latency relative to the dot.
- `lyc_match` is updated every clk from registered `ly` and the live `lyc`. It lags a change of `ly` or `lyc` by 1 clk.
- `stat_irq` lags the `stat_line` rising edge by 1 clk.
  - A `stat_sel` write that raises `stat_line` while a condition already holds fires `stat_irq`.
- A `stat_line` that stays high across a mode change produces no second pulse.
- `drawline`, `frame_start` and `vblank_irq` are exactly one clk wide, independent of `dot_en` spacing.
- Simultaneous events:
  - A dot wrap plus a `lcd_enable` fall: the disable wins.
  - A `vblank_irq` and a `stat_irq` in the same clk are both asserted.

## Configuration
- `LCD_STAT_BLOCKING_EN` defined:
  - `stat_irq` fires only on the rising edge of the ORed `stat_line`. This is STAT blocking, and it is the behaviour described above.
- Not defined:
  - Each of the four sel-qualified conditions is edge-detected separately.
  - `stat_irq` pulses when any individual condition rises, even if another condition is already high.

## Test plan
- Reset, `dot_en` = 1, `lcd_enable` = 1 → `frame_start` pulses at cycle 1. `mode` = 2 at dots 0–79, 3 at dots 80–251, 0 at dots 252–455. `drawline` pulses once per line at dot 80. `oam_locked`/`vram_locked` follow.
- Run a full frame → `ly` goes 0..153 and wraps. `vblank_irq` is a single pulse at the `ly` = 144 entry. Mode is 1 for lines 144–153. Total frame length is 70224 dots.
- `lyc` = 10, `stat_sel` = 4'b1000 → `lyc_match` is high for line 10 only, and `stat_irq` pulses once at the line-10 entry plus 1 clk.
- `stat_sel` = 4'b1001, `lyc` = 0 at the end of line 153 → with the `_EN` macro, one `stat_irq` across the H-blank/LYC overlap. Without it, an extra pulse where the second condition rises.
- Deassert `lcd_enable` at line 50, dot 200 → next clk: `ly` = 0, `mode` = 0, locks = 0. Re-enable → mode 2 and `frame_start` pulse.
- `dot_en` every 4th clk → line length is 1824 clk. All pulses remain 1 clk wide.
